npc_pc_unit: RTL
================

Name: npc_pc_unit

Overview:
- Next-generation fetch-address unit: owns the F-stage PC register and the delay-slot flag that travels with the instruction into D.
- Computes the next PC from the D-stage control-transfer decision: sequential, branch, jump-index, jump-register or eret.
- Exception entry overrides every other source.
- Parametrised in PC width, reset vector, handler vector and legal instruction-memory window; flags address-error fetches (AdEL).

Parameters:
PC_W, 32, width of every PC/target bus (>= 28)
RESET_PC, 32'h0000_3000, pc_f value after reset
EXC_PC, 32'h0000_4180, exception handler entry address
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6ffc, highest legal fetch address (inclusive)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
stall  in  1  freeze F and D (hazard unit)
exc_req  in  1  exception/interrupt taken this cycle; highest priority after reset
op  in  3  D-stage transfer: 0 SEQ, 1 BR, 2 J, 3 JR, 4 ERET, others treated as SEQ
cmp_out  in  1  branch condition from D comparator
pc_d  in  PC_W  PC of the instruction in D
offset  in  16  branch immediate
instr_index  in  26  jump index field
reg_target  in  PC_W  forwarded rs value for JR
epc  in  PC_W  CP0 EPC
pc_f  out  PC_W  current fetch address
bd_d  out  1  instruction now in D is a delay slot
flush_f  out  1  discard the instruction fetched this cycle (ERET)
adel_f  out  1  pc_f misaligned or outside [IM_BASE, IM_LIMIT]

Behaviour:
Reset:
- pc_f = RESET_PC, bd_d = 0.
- flush_f and adel_f follow from their equations.
- Reset wins over exc_req and stall.

Next-PC selection (npc, combinational):
- SEQ: pc_f + 4.
- BR: cmp_out ? pc_d + 4 + sext(offset)<<2 : pc_f + 4.
- J: {pc_d[PC_W-1:28], instr_index, 2'b00}.
- JR: reg_target.
- ERET: epc.
- All adds are modulo 2^PC_W; 32'hffff_fffc + 4 wraps to 0, and adel_f then asserts.

Register update at each rising edge, first matching rule wins:
- reset: values above.
- exc_req: pc_f <= EXC_PC, bd_d <= 0. Applies even when stall = 1.
- stall: pc_f and bd_d hold. op is ignored; D is frozen, so op re-presents next cycle.
- otherwise: pc_f <= npc. bd_d <= 1 iff op in {BR, J, JR}, whether taken or not.

flush_f:
- Equals (op == ERET) && !stall && !exc_req && !reset.
- Combinational, same cycle. D captures a nop instead of the fetched word.
- ERET has no delay slot, so bd_d <= 0 on ERET.

adel_f:
- Equals (pc_f[1:0] != 0) || pc_f < IM_BASE || pc_f > IM_LIMIT.
- Unsigned compare, derived from the register only; no dependence on stall.
- The unit does not redirect on adel_f; the exception path raises exc_req.

Timing rules:
- Latency: one cycle from op/exc_req to the new pc_f.
- A branch in D redirects the fetch after the delay slot, because pc_f already holds pc_d + 4 when op is sampled.
- Simultaneous exc_req and ERET: the exception wins; pc_f = EXC_PC and flush_f = 0.
- Reset asserted mid-stall or mid-redirect: pending state is discarded and RESET_PC is loaded.

Test Plan:
1. Reset, then 3 free cycles with op = SEQ -> pc_f sequence 0x3000, 0x3004, 0x3008, 0x300c; bd_d = 0; adel_f = 0.
2. pc_d = 0x3008, pc_f = 0x300c, op = BR, offset = 0xfffe. Taken (cmp_out = 1) -> pc_f = 0x3004, bd_d = 1. Untaken -> pc_f = 0x3010, bd_d = 1.
3. op = J, pc_d = 0x3010, instr_index = 0x0000c40 -> pc_f = 0x3100. op = JR, reg_target = 0x3002 -> pc_f = 0x3002 and adel_f = 1.
4. stall = 1 for 2 cycles with op = JR, reg_target = 0x3400 -> pc_f and bd_d hold. Stall drops -> pc_f = 0x3400 next edge.
5. op = ERET, epc = 0x3020 -> flush_f = 1 in the same cycle, pc_f = 0x3020, bd_d = 0. Repeat with exc_req = 1 -> pc_f = 0x4180, flush_f = 0. Repeat with stall = 1, exc_req = 1 -> pc_f = 0x4180.
6. Reset asserted while stall = 1 and op = BR taken -> pc_f = 0x3000, bd_d = 0 the next cycle. pc_f forced past IM_LIMIT (SEQ from 0x6ffc) -> pc_f = 0x7000 and adel_f = 1.

Source files
------------

// File: rtl/npc_pc_unit.sv
// Fetch-address unit: holds the F-stage PC and the delay-slot flag for D,
// selects the next PC from the D-stage transfer decision, and flags AdEL fetches.
module npc_pc_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [PC_W-1:0] EXC_PC   = 32'h0000_4180,
    parameter logic [PC_W-1:0] IM_BASE  = 32'h0000_3000,
    parameter logic [PC_W-1:0] IM_LIMIT = 32'h0000_6ffc
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            exc_req,
    input  logic [2:0]      op,
    input  logic            cmp_out,
    input  logic [PC_W-1:0] pc_d,
    input  logic [15:0]     offset,
    input  logic [25:0]     instr_index,
    input  logic [PC_W-1:0] reg_target,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] pc_f,
    output logic            bd_d,
    output logic            flush_f,
    output logic            adel_f
);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_JR   = 3'd3;
    localparam logic [2:0] OP_ERET = 3'd4;

    // Low 28 bits replaced by a J target; also valid when PC_W is exactly 28.
    localparam logic [PC_W-1:0] LOW28_MASK = PC_W'(28'hfff_ffff);
    localparam logic [PC_W-1:0] FOUR       = PC_W'(4);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] j_pc;
    logic [PC_W-1:0] npc;
    logic            is_cti;

    assign seq_pc = pc_f + FOUR;
    assign br_pc  = pc_d + FOUR + {{(PC_W-18){offset[15]}}, offset, 2'b00};
    assign j_pc   = (pc_d & ~LOW28_MASK) | PC_W'({instr_index, 2'b00});

    always_comb begin
        npc = seq_pc;
        case (op)
            OP_SEQ:  npc = seq_pc;
            OP_BR:   npc = cmp_out ? br_pc : seq_pc;
            OP_J:    npc = j_pc;
            OP_JR:   npc = reg_target;
            OP_ERET: npc = epc;
            default: npc = seq_pc;
        endcase
    end

    // The instruction following any branch or jump is a delay slot, taken or not.
    assign is_cti = (op == OP_BR) || (op == OP_J) || (op == OP_JR);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= RESET_PC;
            bd_d <= 1'b0;
        end else if (exc_req) begin
            pc_f <= EXC_PC;
            bd_d <= 1'b0;
        end else if (!stall) begin
            pc_f <= npc;
            bd_d <= is_cti;
        end
    end

    // ERET has no delay slot, so the word fetched alongside it is squashed.
    assign flush_f = (op == OP_ERET) && !stall && !exc_req && !reset;

    assign adel_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_LIMIT);

endmodule
